// File: rtl/sdram_bus_arbiter4_if.sv
// Bus-ownership signals between the four write-bus masters and the
// arbiter that steers the SDRAM controller's 4:1 data mux.
interface sdram_bus_arbiter4_if #(
  parameter int CNT_WIDTH = 4
);
  logic [3:0]           req;
  logic                 slave_ready;
  logic [3:0]           grant;
  logic [1:0]           mux_sel;
  logic                 bus_valid;
  logic [CNT_WIDTH-1:0] beat_count;
  logic                 burst_done;

  // Arbiter side: owns grant/select, observes requests and controller ready.
  modport master (
    input  req, slave_ready,
    output grant, mux_sel, bus_valid, beat_count, burst_done
  );

  // Master/controller side: raises requests, sees grant and status.
  modport slave (
    output req, slave_ready,
    input  grant, mux_sel, bus_valid, beat_count, burst_done
  );
endinterface

// File: rtl/sdram_bus_arbiter4.sv
// Four-master round-robin arbiter for the SDRAM write bus.
// Each tenure is bounded to MAX_BURST accepted beats; every change of
// ownership passes through one IDLE cycle with grant=0 so the data mux
// select settles before a new owner's data is qualified.
module sdram_bus_arbiter4 #(
  parameter int MAX_BURST = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sdram_bus_arbiter4_if.master  bus
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  // Count value that, with one more beat, closes the tenure.
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BURST - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(MAX_BURST);

  state_t     state;
  logic [1:0] ptr;       // last owner; search starts just after it
  logic [1:0] winner;
  logic       any_req;
  logic       owner_req;
  logic       beat;

  // Owner still has data and the bus is granted to it.
  assign bus.bus_valid = |(bus.grant & bus.req);
  assign beat          = bus.bus_valid & bus.slave_ready;
  // In OWN, mux_sel always holds the owner's index.
  assign owner_req     = bus.req[bus.mux_sel];
  assign any_req       = |bus.req;

  // Round-robin pick: scan ptr+4 down to ptr+1 so the nearest requester
  // after ptr is the last assignment and therefore wins.
  always_comb begin
    winner = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[ptr + 2'(k)]) winner = ptr + 2'(k);
    end
  end

  // Ownership FSM with registered grant, select, counter and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= 2'd3;
      bus.grant      <= 4'b0000;
      bus.mux_sel    <= 2'd0;
      bus.beat_count <= '0;
      bus.burst_done <= 1'b0;
    end else begin
      bus.burst_done <= 1'b0;
      case (state)
        IDLE: begin
          // mux_sel and beat_count hold until the next tenure starts.
          if (any_req) begin
            bus.grant      <= 4'b0001 << winner;
            bus.mux_sel    <= winner;
            bus.beat_count <= '0;
            state          <= OWN;
          end
        end
        OWN: begin
          if (!owner_req) begin
            // Voluntary release; no beat is possible this cycle.
            bus.grant <= 4'b0000;
            ptr       <= bus.mux_sel;
            state     <= IDLE;
          end else if (beat) begin
            if (bus.beat_count == LAST_BEAT) begin
              bus.beat_count <= FULL_CNT;
              bus.grant      <= 4'b0000;
              bus.burst_done <= 1'b1;
              ptr            <= bus.mux_sel;
              state          <= IDLE;
            end else begin
              bus.beat_count <= bus.beat_count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdram_bus_arbiter4.md
# sdram_bus_arbiter4

Four-master round-robin arbiter for the unidirectional write bus into the SDRAM controller. It drives the 2-bit select of the 4:1 bus data mux and a one-hot grant to the masters. Each master gets a bounded burst tenure, and ownership changes only through one dead cycle so the mux select settles before data is qualified. It sits between the four bus masters and the SDRAM controller's command/data input.

## Interface
- MAX_BURST, 8: maximum accepted beats per tenure (legal 1..2^CNT_WIDTH-1).
- CNT_WIDTH, 4: width of the beat counter.
- Clk  input  1  single clock; all state changes on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Req  input  4  level request per master, bit i = master i; held high while the master has data.
- SlaveReady  input  1  SDRAM controller accepts a beat this cycle.
- Grant  output  4  registered one-hot grant; all-zero when no owner.
- MuxSel  output  2  registered select to the 4:1 data mux; index of the current or last owner.
- BusValid  output  1  combinational; equals |(Grant & Req).
- BeatCount  output  CNT_WIDTH  registered count of beats accepted in the current tenure.
- BurstDone  output  1  registered one-cycle pulse when a tenure ends by reaching MAX_BURST.

## Operation
- Beat: any cycle with BusValid=1 and SlaveReady=1.
- Internal round-robin pointer Ptr[1:0] holds the last owner. Search order is Ptr+1, Ptr+2, Ptr+3, Ptr (mod 4).
- Reset values: Grant=0, MuxSel=0, BeatCount=0, BurstDone=0, Ptr=3 (master 0 wins first), state=IDLE.
- IDLE state:
  - Grant=0, so BusValid=0.
  - If any Req bit is high at the edge, the winner w is the first requester in search order.
  - At that edge: Grant<=1<<w, MuxSel<=w, BeatCount<=0, state<=OWN.
  - With no request, the state stays IDLE and MuxSel holds its value.
- OWN state, owner o:
  - BeatCount increments on each beat.
  - Req[o]=0 at the edge: release. Grant<=0, Ptr<=o, state<=IDLE, BurstDone stays 0. No beat occurs in that cycle.
  - A beat that makes BeatCount reach MAX_BURST: Grant<=0, Ptr<=o, BurstDone<=1 for one cycle, state<=IDLE. BeatCount shows MAX_BURST during the IDLE cycle.
  - SlaveReady=0 stalls the tenure. Tenure length has no cycle limit; only accepted beats count.
  - Req changes from non-owners are ignored until IDLE.
- A master that still requests after MAX_BURST re-enters arbitration with the lowest priority.
- Grant must always be one-hot or zero. MuxSel must equal the index of the set Grant bit whenever Grant≠0.
- Asynchronous reset at any point forces all reset values immediately. A partially transferred burst is abandoned; no recovery is required.

## Timing
- Request to grant: Req high before edge k in IDLE gives Grant visible in cycle k+1. The first beat is possible in cycle k+1.
- Ownership change: minimum 1 dead cycle (IDLE) between tenures, with Grant=0 and BusValid=0.
- Back-to-back maximum: MAX_BURST beats per MAX_BURST+1 cycles with a continuous request and SlaveReady=1.
- BusValid drops in the same cycle that the owner drops Req.
- MuxSel changes only on the edge that enters OWN, never during a tenure.
- BurstDone is high only during the IDLE cycle that follows the final beat.

## Test plan
- Reset: assert Rst_n=0 mid-run and hold 3 cycles. Required: Grant=0, MuxSel=0, BeatCount=0, BurstDone=0 immediately, without a clock edge. After release, Req=4'b1111 grants master 0 first.
- Single master, defaults: Req=4'b0100, SlaveReady=1 for 20 cycles. Required: Grant=4'b0100 and MuxSel=2 for cycles 1–8, then 1 IDLE cycle with BurstDone=1, then regranted to 2.
- Full contention: Req=4'b1111 and SlaveReady=1 held. Required grant order 0,1,2,3,0. Each tenure is 8 cycles with a 1-cycle gap; Grant is never multi-hot.
- Early release: master 1 owns and drops Req after 3 beats while Req[3] and Req[0] are pending. Required: BurstDone=0, BeatCount=3, then the next grant goes to 3 (the search starts after Ptr=1), then 0.
- Stall: master 3 owns with SlaveReady toggling 1,0,0,1,... Required: BeatCount advances only on ready cycles, and the tenure ends exactly at the 8th accepted beat.
- Idle hold: release with no pending Req. Required: Grant=0, BusValid=0, and MuxSel keeps the last owner index indefinitely.
